// File: rtl/punt_tmr_pkg.sv
// Shared game definitions: message codes and default widths for the timer and ranking stages.
// No logic here; no latency or backpressure.
package punt_tmr_pkg;

    localparam int MENS_BITS_DEF = 4;
    localparam int PUN_BITS_DEF  = 7;

    typedef enum logic [3:0] {
        MSG_IDLE = 4'b0000,
        MSG_ARM  = 4'b0010,
        MSG_RUN  = 4'b0100,
        MSG_PUN  = 4'b1000
    } msg_e;

endpackage

// File: rtl/punt_tmr_tick_gen.sv
// Prescaler: one-cycle tick every DIV cycles, restarted by clr. Tick is a compare on the count register.
// No backpressure; clr wins over counting.
module tick_gen #(
    parameter int DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = (cnt_q == CW'(DIV - 1));

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/punt_tmr.sv
// Reaction timer: arming delay, then scores the stop response in prescaled units.
// Outputs registered, one cycle after the deciding edge; no backpressure, stop/start are levels.
module punt_tmr
    import punt_tmr_pkg::*;
#(
    parameter int MENS_BITS = MENS_BITS_DEF,
    parameter int PUN_BITS  = PUN_BITS_DEF,
    parameter int DIV       = 50000,
    parameter int ARM_UNITS = 100
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stop,
    output logic [MENS_BITS-1:0] data,
    output logic [PUN_BITS-1:0]  pun,
    output logic                 busy
);

    localparam int PUN_TOP = (1 << PUN_BITS) - 1;
    localparam int ARM_W   = $clog2(ARM_UNITS + 1);
    localparam int CNT_W   = (PUN_BITS > ARM_W) ? PUN_BITS : ARM_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_RUN,
        S_DONE
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [PUN_BITS-1:0]   pun_q, pun_d;
    logic [MENS_BITS-1:0]  data_q, data_d;
    logic                  busy_q, busy_d;
    logic                  tick;
    logic                  clr;

    tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .tick (tick)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pun_d   = pun_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) state_d = S_ARM;
            end
            // A false start outranks the final arming tick.
            S_ARM: begin
                if (stop) begin
                    state_d = S_DONE;
                    pun_d   = PUN_BITS'(PUN_TOP);
                end else if (tick) begin
                    if (cnt_q == CNT_W'(ARM_UNITS - 1)) state_d = S_RUN;
                    else                                cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            S_RUN: begin
                if (stop) begin
                    state_d = S_DONE;
                    pun_d   = PUN_BITS'(cnt_q);
                end else if (tick) begin
                    if (cnt_q == CNT_W'(PUN_TOP - 1)) begin
                        state_d = S_DONE;
                        pun_d   = PUN_BITS'(PUN_TOP);
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_DONE: begin
                if (start) state_d = S_ARM;
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d != state_q) cnt_d = '0;

        // Prescaler restarts on every entry and idles outside the timed states.
        clr = (state_d != state_q) || !((state_q == S_ARM) || (state_q == S_RUN));

        data_d = MENS_BITS'(MSG_IDLE);
        unique case (state_d)
            S_ARM:   data_d = MENS_BITS'(MSG_ARM);
            S_RUN:   data_d = MENS_BITS'(MSG_RUN);
            S_DONE:  data_d = MENS_BITS'(MSG_PUN);
            default: data_d = MENS_BITS'(MSG_IDLE);
        endcase
        busy_d = (state_d == S_ARM) || (state_d == S_RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            pun_q   <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pun_q   <= pun_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
        end
    end

    assign data = data_q;
    assign pun  = pun_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_punt_tmr.sv
// Bench for punt_tmr with small DIV/ARM_UNITS: directed rounds, then random rounds against a cycle-count model.
module tb_punt_tmr;

    localparam int DIV_P = 4;
    localparam int ARM_P = 2;
    localparam int PB    = 7;
    localparam int PMAX  = (1 << PB) - 1;

    logic          clk;
    logic          rst;
    logic          start;
    logic          stop;
    logic [3:0]    data;
    logic [PB-1:0] pun;
    logic          busy;

    int checks = 0;
    int errors = 0;

    // Model: mode 0 idle, 1 arming, 2 running, 3 done; m_el counts cycles since entering the mode.
    int m_mode = 0;
    int m_el   = 0;
    int m_pun  = 0;

    punt_tmr #(
        .MENS_BITS (4),
        .PUN_BITS  (PB),
        .DIV       (DIV_P),
        .ARM_UNITS (ARM_P)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .stop  (stop),
        .data  (data),
        .pun   (pun),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0d exp=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int code_of(input int mode);
        case (mode)
            1:       return 2;
            2:       return 4;
            3:       return 8;
            default: return 0;
        endcase
    endfunction

    task automatic model_step(input bit s, input bit t);
        bit tk;
        int u;
        tk = ((m_el + 1) % DIV_P) == 0;
        u  = m_el / DIV_P;
        case (m_mode)
            1: begin
                if (t) begin
                    m_mode = 3; m_pun = PMAX;
                end else if (tk && (u + 1 == ARM_P)) begin
                    m_mode = 2; m_el = 0;
                end else begin
                    m_el++;
                end
            end
            2: begin
                if (t) begin
                    m_mode = 3; m_pun = u;
                end else if (tk && (u + 1 == PMAX)) begin
                    m_mode = 3; m_pun = PMAX;
                end else begin
                    m_el++;
                end
            end
            default: begin
                if (s) begin
                    m_mode = 1; m_el = 0;
                end
            end
        endcase
    endtask

    task automatic check_outs(input string tag);
        chk({tag, "_data"}, data, code_of(m_mode));
        chk({tag, "_pun"},  pun,  m_pun);
        chk({tag, "_busy"}, busy, (m_mode == 1 || m_mode == 2) ? 1 : 0);
    endtask

    task automatic step(input bit s, input bit t);
        start = s;
        stop  = t;
        @(posedge clk);
        model_step(s, t);
        #1;
        check_outs("cyc");
    endtask

    // Called one time unit after an edge: reset lands between edges.
    task automatic async_reset();
        #2;
        rst   = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        #1;
        chk("rst_data", data, 0);
        chk("rst_pun",  pun,  0);
        chk("rst_busy", busy, 0);
        m_mode = 0; m_el = 0; m_pun = 0;
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        int kind;
        int len;
        int rst_at;
        rst   = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        #12;
        chk("por_data", data, 0);
        chk("por_pun",  pun,  0);
        chk("por_busy", busy, 0);
        @(posedge clk);
        #2;
        rst = 1'b0;

        step(0, 1);
        chk("idle_stop_ignored", data, 0);

        // Normal round scoring 13.
        step(1, 0);
        chk("arm_entry", data, 2);
        repeat (7) step(0, 0);
        chk("arm_hold", data, 2);
        step(0, 0);
        chk("run_entry", data, 4);
        repeat (55) step(0, 0);
        step(0, 1);
        chk("norm_data", data, 8);
        chk("norm_pun",  pun,  13);
        chk("norm_busy", busy, 0);

        // Restart from DONE keeps the previous score visible.
        step(1, 0);
        chk("b2b_data", data, 2);
        chk("b2b_pun",  pun,  13);

        repeat (3) step(0, 0);
        step(0, 1);
        chk("false_data", data, 8);
        chk("false_pun",  pun,  PMAX);

        async_reset();
        step(1, 1);
        chk("startstop_idle", data, 2);

        // Stop coincident with the tick that would make the count 6.
        repeat (8) step(0, 0);
        repeat (23) step(0, 0);
        step(0, 1);
        chk("coinc_pun", pun, 5);

        // Timeout without a stop.
        step(1, 0);
        repeat (8) step(0, 0);
        repeat (507) step(0, 0);
        chk("pre_timeout", data, 4);
        step(0, 0);
        chk("timeout_data", data, 8);
        chk("timeout_pun",  pun,  PMAX);
        repeat (10) step(0, 0);
        chk("timeout_hold", pun, PMAX);

        // Reset mid-run, then a clean round.
        step(1, 0);
        repeat (28) step(0, 0);
        async_reset();
        repeat (5) step(0, 0);
        step(1, 0);
        repeat (8) step(0, 0);
        repeat (11) step(0, 0);
        step(0, 1);
        chk("after_rst_pun", pun, 2);

        for (int r = 0; r < 30; r++) begin
            repeat ($urandom_range(0, 3)) step(0, 1'($urandom_range(0, 1)));
            step(1, $urandom_range(0, 5) == 0);
            kind = $urandom_range(0, 2);
            case (kind)
                0:       len = $urandom_range(0, 12);
                1:       len = $urandom_range(8, 300);
                default: len = 530;
            endcase
            rst_at = ($urandom_range(0, 7) == 0) ? len / 2 : -1;
            for (int i = 0; i < len; i++) begin
                if (i == rst_at) async_reset();
                step($urandom_range(0, 15) == 0, 1'b0);
            end
            step(0, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
